// File: rtl/hazard_pkg.sv
// Shared definitions for the scoreboard hazard unit: forwarding selects,
// canonical producer latencies and the forwarding priority helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  localparam int unsigned LAT_ALU  = 0;
  localparam int unsigned LAT_LOAD = 1;

  // M-stage result is younger than W, so it wins when both match.
  function automatic fwd_sel_e fwd_pick(input logic m_hit, input logic w_hit);
    if (m_hit)      return FWD_M;
    else if (w_hit) return FWD_W;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_unit_sb_if.sv
// Pipeline <-> hazard unit signal bundle. The pipeline side is the master,
// the hazard unit is the slave.
interface hazard_unit_sb_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned LAT_W  = 6,
  parameter int unsigned CNT_W  = 32
);
  import hazard_pkg::*;

  // D stage
  logic [REG_AW-1:0] rs_d;
  logic [REG_AW-1:0] rt_d;
  logic              use_rs_d;
  logic              use_rt_d;
  logic              src_stage_d;
  logic              wr_en_d;
  logic [REG_AW-1:0] wr_reg_d;
  logic [LAT_W-1:0]  wr_lat_d;
  logic              mdu_start_d;
  logic [LAT_W-1:0]  mdu_lat_d;
  logic              hilo_read_d;
  logic              branch_taken_d;
  logic              jump_d;
  logic              exc_flush;
  // E / M / W stages
  logic [REG_AW-1:0] rs_e;
  logic [REG_AW-1:0] rt_e;
  logic              wr_en_m;
  logic [REG_AW-1:0] wr_reg_m;
  logic              wr_en_w;
  logic [REG_AW-1:0] wr_reg_w;
  // hazard controls
  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic              flush_e;
  logic              fwd_a_d;
  logic              fwd_b_d;
  fwd_sel_e          fwd_a_e;
  fwd_sel_e          fwd_b_e;
  logic              mdu_busy;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output rs_d, rt_d, use_rs_d, use_rt_d, src_stage_d, wr_en_d, wr_reg_d,
           wr_lat_d, mdu_start_d, mdu_lat_d, hilo_read_d, branch_taken_d,
           jump_d, exc_flush, rs_e, rt_e, wr_en_m, wr_reg_m, wr_en_w, wr_reg_w,
    input  stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d, fwd_a_e,
           fwd_b_e, mdu_busy, stall_cnt
  );

  modport slave (
    input  rs_d, rt_d, use_rs_d, use_rt_d, src_stage_d, wr_en_d, wr_reg_d,
           wr_lat_d, mdu_start_d, mdu_lat_d, hilo_read_d, branch_taken_d,
           jump_d, exc_flush, rs_e, rt_e, wr_en_m, wr_reg_m, wr_en_w, wr_reg_w,
    output stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d, fwd_a_e,
           fwd_b_e, mdu_busy, stall_cnt
  );

endinterface

// File: rtl/hazard_sb_tbl.sv
// Per-register countdown table: one countdown per GPR, set on issue,
// decremented each cycle, cleared on flush. r0 is never recorded.
module hazard_sb_tbl #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CW     = 7
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_reg,
  input  logic [CW-1:0]     set_val,
  input  logic [REG_AW-1:0] rd_a_reg,
  output logic [CW-1:0]     rd_a_cnt,
  input  logic [REG_AW-1:0] rd_b_reg,
  output logic [CW-1:0]     rd_b_cnt
);

  logic [CW-1:0] cnt [NREG];

  // Countdown update: clear beats set, set beats decrement.
  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < NREG; r++) begin
      if (!resetn || clear)
        cnt[r] <= '0;
      else if (set_en && (r != 0) && (set_reg == REG_AW'(r)))
        cnt[r] <= set_val;
      else if (cnt[r] != '0)
        cnt[r] <= cnt[r] - CW'(1);
    end
  end

  // Two combinational read ports for the D-stage sources.
  always_comb begin
    rd_a_cnt = cnt[rd_a_reg];
    rd_b_cnt = cnt[rd_b_reg];
  end

endmodule

// File: rtl/hazard_unit_sb.sv
// Scoreboard hazard unit: data/MDU stalls, front-end flushes, M/W
// forwarding selects and a saturating stall counter.
module hazard_unit_sb
  import hazard_pkg::*;
#(
  parameter int unsigned NREG       = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned LAT_W      = 6,
  parameter int unsigned CNT_W      = 32,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input logic       clk,
  input logic       resetn,
  hazard_unit_sb_if.slave hz
);

  // One extra bit so wr_lat_d+1 never wraps at the LAT_W maximum.
  localparam int unsigned CW = LAT_W + 1;

  logic [CW-1:0]    cnt_rs;
  logic [CW-1:0]    cnt_rt;
  logic [LAT_W-1:0] mdu_cnt;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             issue;
  logic             rs_stall;
  logic             rt_stall;
  logic             data_stall;
  logic             mdu_stall;
  logic             stall;

  hazard_sb_tbl #(
    .NREG   (NREG),
    .REG_AW (REG_AW),
    .CW     (CW)
  ) u_tbl (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (hz.exc_flush),
    .set_en   (issue & hz.wr_en_d),
    .set_reg  (hz.wr_reg_d),
    .set_val  (CW'(hz.wr_lat_d) + CW'(1)),
    .rd_a_reg (hz.rs_d),
    .rd_a_cnt (cnt_rs),
    .rd_b_reg (hz.rt_d),
    .rd_b_cnt (cnt_rt)
  );

  // Stall decision. A D-stage consumer needs the value one cycle earlier
  // than an E-stage consumer, hence the >0 versus >1 thresholds.
  always_comb begin
    rs_stall   = hz.use_rs_d & (hz.rs_d != '0) &
                 (hz.src_stage_d ? (cnt_rs != '0) : (cnt_rs > CW'(1)));
    rt_stall   = hz.use_rt_d & (hz.rt_d != '0) &
                 (hz.src_stage_d ? (cnt_rt != '0) : (cnt_rt > CW'(1)));
    data_stall = rs_stall | rt_stall;
    mdu_stall  = (hz.hilo_read_d | hz.mdu_start_d) & (mdu_cnt != '0);
    stall      = data_stall | mdu_stall;
    issue      = ~stall & ~hz.exc_flush;
  end

  // MDU occupancy countdown.
  always_ff @(posedge clk) begin
    if (!resetn || hz.exc_flush)
      mdu_cnt <= '0;
    else if (issue && hz.mdu_start_d)
      mdu_cnt <= hz.mdu_lat_d;
    else if (mdu_cnt != '0)
      mdu_cnt <= mdu_cnt - LAT_W'(1);
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (!resetn)
      stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  // Pipeline control and forwarding outputs.
  always_comb begin
    hz.stall_d   = stall;
    hz.stall_f   = stall;
    hz.flush_e   = stall | hz.exc_flush;
    hz.flush_d   = hz.exc_flush |
                   (!DELAY_SLOT & (hz.branch_taken_d | hz.jump_d) & ~stall);
    hz.fwd_a_d   = hz.wr_en_m & (hz.wr_reg_m != '0) & (hz.wr_reg_m == hz.rs_d);
    hz.fwd_b_d   = hz.wr_en_m & (hz.wr_reg_m != '0) & (hz.wr_reg_m == hz.rt_d);
    hz.fwd_a_e   = fwd_pick(hz.wr_en_m & (hz.wr_reg_m != '0) & (hz.wr_reg_m == hz.rs_e),
                            hz.wr_en_w & (hz.wr_reg_w != '0) & (hz.wr_reg_w == hz.rs_e));
    hz.fwd_b_e   = fwd_pick(hz.wr_en_m & (hz.wr_reg_m != '0) & (hz.wr_reg_m == hz.rt_e),
                            hz.wr_en_w & (hz.wr_reg_w != '0) & (hz.wr_reg_w == hz.rt_e));
    hz.mdu_busy  = (mdu_cnt != '0);
    hz.stall_cnt = stall_cnt_q;
  end

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed bench for hazard_unit_sb: one instance with a delay slot, one
// without, driven by the same stimulus.
module tb_hazard_unit_sb;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] rs_d, rt_d, wr_reg_d, rs_e, rt_e, wr_reg_m, wr_reg_w;
  logic       use_rs_d, use_rt_d, src_stage_d, wr_en_d, mdu_start_d;
  logic       hilo_read_d, branch_taken_d, jump_d, exc_flush, wr_en_m, wr_en_w;
  logic [5:0] wr_lat_d, mdu_lat_d;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  hazard_unit_sb_if #(.REG_AW(5), .LAT_W(6), .CNT_W(32)) h1 ();
  hazard_unit_sb_if #(.REG_AW(5), .LAT_W(6), .CNT_W(32)) h0 ();

  hazard_unit_sb #(.NREG(32), .REG_AW(5), .LAT_W(6), .CNT_W(32), .DELAY_SLOT(1'b1))
    dut (.clk(clk), .resetn(resetn), .hz(h1));
  hazard_unit_sb #(.NREG(32), .REG_AW(5), .LAT_W(6), .CNT_W(32), .DELAY_SLOT(1'b0))
    dut0 (.clk(clk), .resetn(resetn), .hz(h0));

  always_comb begin
    h1.rs_d = rs_d;               h0.rs_d = rs_d;
    h1.rt_d = rt_d;               h0.rt_d = rt_d;
    h1.use_rs_d = use_rs_d;       h0.use_rs_d = use_rs_d;
    h1.use_rt_d = use_rt_d;       h0.use_rt_d = use_rt_d;
    h1.src_stage_d = src_stage_d; h0.src_stage_d = src_stage_d;
    h1.wr_en_d = wr_en_d;         h0.wr_en_d = wr_en_d;
    h1.wr_reg_d = wr_reg_d;       h0.wr_reg_d = wr_reg_d;
    h1.wr_lat_d = wr_lat_d;       h0.wr_lat_d = wr_lat_d;
    h1.mdu_start_d = mdu_start_d; h0.mdu_start_d = mdu_start_d;
    h1.mdu_lat_d = mdu_lat_d;     h0.mdu_lat_d = mdu_lat_d;
    h1.hilo_read_d = hilo_read_d; h0.hilo_read_d = hilo_read_d;
    h1.branch_taken_d = branch_taken_d; h0.branch_taken_d = branch_taken_d;
    h1.jump_d = jump_d;           h0.jump_d = jump_d;
    h1.exc_flush = exc_flush;     h0.exc_flush = exc_flush;
    h1.rs_e = rs_e;               h0.rs_e = rs_e;
    h1.rt_e = rt_e;               h0.rt_e = rt_e;
    h1.wr_en_m = wr_en_m;         h0.wr_en_m = wr_en_m;
    h1.wr_reg_m = wr_reg_m;       h0.wr_reg_m = wr_reg_m;
    h1.wr_en_w = wr_en_w;         h0.wr_en_w = wr_en_w;
    h1.wr_reg_w = wr_reg_w;       h0.wr_reg_w = wr_reg_w;
  end

  task automatic idle();
    rs_d = '0; rt_d = '0; use_rs_d = 0; use_rt_d = 0; src_stage_d = 0;
    wr_en_d = 0; wr_reg_d = '0; wr_lat_d = '0; mdu_start_d = 0; mdu_lat_d = '0;
    hilo_read_d = 0; branch_taken_d = 0; jump_d = 0; exc_flush = 0;
    rs_e = '0; rt_e = '0; wr_en_m = 0; wr_reg_m = '0; wr_en_w = 0; wr_reg_w = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    idle();
    resetn = 0;
    tick(); tick();
    resetn = 1;
    settle();
    chk("rst_stall_d", 32'(h1.stall_d), 32'd0);
    chk("rst_stall_f", 32'(h1.stall_f), 32'd0);
    chk("rst_flush_e", 32'(h1.flush_e), 32'd0);
    chk("rst_flush_d", 32'(h1.flush_d), 32'd0);
    chk("rst_mdu_busy", 32'(h1.mdu_busy), 32'd0);
    chk("rst_stall_cnt", h1.stall_cnt, 32'd0);
    tick();
    exc_flush = 1;
    settle();
    chk("exc_flush_e", 32'(h1.flush_e), 32'd1);
    chk("exc_flush_d", 32'(h1.flush_d), 32'd1);

    // load r8 then E-stage consumer add r9,r8,r1
    tick(); idle();
    wr_en_d = 1; wr_reg_d = 8; wr_lat_d = 6'(LAT_LOAD);
    settle();
    chk("lw_issue_stall", 32'(h1.stall_d), 32'd0);
    tick(); idle();
    use_rs_d = 1; rs_d = 8; use_rt_d = 1; rt_d = 1; wr_en_d = 1; wr_reg_d = 9;
    wr_lat_d = 6'(LAT_ALU);
    settle();
    chk("ld_use_stall", 32'(h1.stall_d), 32'd1);
    chk("ld_use_stall_f", 32'(h1.stall_f), 32'd1);
    chk("ld_use_flush_e", 32'(h1.flush_e), 32'd1);
    tick(); settle();
    chk("ld_use_release", 32'(h1.stall_d), 32'd0);
    chk("ld_use_flush_e0", 32'(h1.flush_e), 32'd0);
    tick(); idle();
    rs_e = 8; rt_e = 1; wr_en_w = 1; wr_reg_w = 8;
    settle();
    chk("fwd_a_e_w", 32'(h1.fwd_a_e), 32'(FWD_W));
    chk("fwd_b_e_rf", 32'(h1.fwd_b_e), 32'(FWD_RF));
    wr_en_m = 1; wr_reg_m = 8; #1;
    chk("fwd_a_e_m_prio", 32'(h1.fwd_a_e), 32'(FWD_M));
    rs_e = 0; wr_reg_m = 0; wr_reg_w = 0; #1;
    chk("fwd_a_e_r0", 32'(h1.fwd_a_e), 32'(FWD_RF));

    // addu r9 then beq r9,r0 (taken)
    tick(); idle();
    wr_en_d = 1; wr_reg_d = 9; wr_lat_d = 6'(LAT_ALU);
    settle();
    chk("addu_issue", 32'(h1.stall_d), 32'd0);
    tick(); idle();
    use_rs_d = 1; rs_d = 9; use_rt_d = 1; rt_d = 0; src_stage_d = 1;
    branch_taken_d = 1;
    settle();
    chk("alu_br_stall", 32'(h1.stall_d), 32'd1);
    chk("alu_br_nds_noflush", 32'(h0.flush_d), 32'd0);
    tick(); settle();
    chk("alu_br_release", 32'(h1.stall_d), 32'd0);
    chk("br_nds_flush_d", 32'(h0.flush_d), 32'd1);
    chk("br_ds_flush_d", 32'(h1.flush_d), 32'd0);
    wr_en_m = 1; wr_reg_m = 9; #1;
    chk("fwd_a_d", 32'(h1.fwd_a_d), 32'd1);
    chk("fwd_b_d", 32'(h1.fwd_b_d), 32'd0);
    // lw r9 then beq r9
    tick(); idle();
    wr_en_d = 1; wr_reg_d = 9; wr_lat_d = 6'(LAT_LOAD);
    settle();
    chk("lw9_issue", 32'(h1.stall_d), 32'd0);
    tick(); idle();
    use_rs_d = 1; rs_d = 9; src_stage_d = 1;
    settle();
    chk("ld_br_stall1", 32'(h1.stall_d), 32'd1);
    tick(); settle();
    chk("ld_br_stall2", 32'(h1.stall_d), 32'd1);
    tick(); settle();
    chk("ld_br_release", 32'(h1.stall_d), 32'd0);
    tick(); idle();
    jump_d = 1;
    settle();
    chk("jump_nds_flush_d", 32'(h0.flush_d), 32'd1);
    chk("jump_ds_flush_d", 32'(h1.flush_d), 32'd0);

    // div (32 cycles) then mflo, then mult
    tick(); idle();
    resetn = 0;
    tick();
    resetn = 1;
    mdu_start_d = 1; mdu_lat_d = 6'd32;
    settle();
    chk("div_issue", 32'(h1.stall_d), 32'd0);
    chk("div_cnt0", h1.stall_cnt, 32'd0);
    tick(); idle();
    hilo_read_d = 1;
    for (int i = 0; i < 32; i++) begin
      settle();
      chk("mflo_stall", 32'(h1.stall_d), 32'd1);
      if (i == 0) chk("mdu_busy_hi", 32'(h1.mdu_busy), 32'd1);
      tick();
    end
    settle();
    chk("mflo_release", 32'(h1.stall_d), 32'd0);
    chk("mdu_busy_lo", 32'(h1.mdu_busy), 32'd0);
    chk("stall_cnt_32", h1.stall_cnt, 32'd32);
    tick(); idle();
    mdu_start_d = 1; mdu_lat_d = 6'd5;
    settle();
    chk("mult_no_stall", 32'(h1.stall_d), 32'd0);
    tick(); idle();
    settle();
    chk("mult_busy", 32'(h1.mdu_busy), 32'd1);

    // pending load to r8 killed by an exception flush
    tick(); idle();
    wr_en_d = 1; wr_reg_d = 8; wr_lat_d = 6'(LAT_LOAD);
    settle();
    tick(); idle();
    exc_flush = 1;
    wr_en_d = 1; wr_reg_d = 8; wr_lat_d = 6'(LAT_LOAD);
    settle();
    chk("exc_flush_d2", 32'(h1.flush_d), 32'd1);
    chk("exc_flush_e2", 32'(h1.flush_e), 32'd1);
    tick(); idle();
    use_rs_d = 1; rs_d = 8; src_stage_d = 1;
    settle();
    chk("post_flush_stall", 32'(h1.stall_d), 32'd0);
    chk("post_flush_mdu", 32'(h1.mdu_busy), 32'd0);

    // r0 producer and unused rt operand
    tick(); idle();
    wr_en_d = 1; wr_reg_d = 0; wr_lat_d = 6'(LAT_LOAD);
    settle();
    tick(); idle();
    use_rs_d = 1; rs_d = 0; src_stage_d = 1;
    settle();
    chk("r0_no_stall", 32'(h1.stall_d), 32'd0);
    tick(); idle();
    wr_en_d = 1; wr_reg_d = 8; wr_lat_d = 6'(LAT_LOAD);
    settle();
    tick(); idle();
    use_rs_d = 1; rs_d = 1; use_rt_d = 0; rt_d = 8; src_stage_d = 1;
    settle();
    chk("unused_rt_no_stall", 32'(h1.stall_d), 32'd0);
    use_rt_d = 1; #1;
    chk("used_rt_stall", 32'(h1.stall_d), 32'd1);

    // reset in the middle of a stall
    resetn = 0;
    tick();
    resetn = 1;
    settle();
    chk("rst_mid_stall_d", 32'(h1.stall_d), 32'd0);
    chk("rst_mid_stall_cnt", h1.stall_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/hazard_unit_sb.md
Name: hazard_unit_sb

Overview:
Scoreboard-based hazard unit, the successor to the current combinational hazard unit in the 5-stage MIPS pipeline.
- Tracks outstanding register writes with per-register countdowns, so load latency and multi-cycle MDU latency are parametrised, not hard-wired.
- Suppresses stalls on unused source operands.
- Keeps the standard M/W forwarding selects.
- Adds exception flush, a delay-slot mode and a stall performance counter.

Parameters:
NREG, 32, number of architectural GPRs tracked (r0 never tracked)
REG_AW, 5, register index width, clog2(NREG)
LAT_W, 6, width of latency fields and countdowns (max 63 cycles)
CNT_W, 32, width of the saturating stall counter
DELAY_SLOT, 1, 1 = branch delay slot architected (flush_d never driven by branches); 0 = flush_d on a taken branch or jump

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
rs_d, rt_d  in  REG_AW each  D-stage source indices
use_rs_d, use_rt_d  in  1 each  D instruction actually reads rs / rt
src_stage_d  in  1  1 = operands consumed in D (branch/jr compare); 0 = consumed in E
wr_en_d  in  1  D instruction writes a GPR
wr_reg_d  in  REG_AW  D destination index
wr_lat_d  in  LAT_W  extra cycles beyond ALU until result is forwardable (ALU 0, load 1)
mdu_start_d  in  1  D instruction is mult/div
mdu_lat_d  in  LAT_W  MDU occupancy cycles for that op
hilo_read_d  in  1  D instruction is mfhi/mflo
branch_taken_d, jump_d  in  1 each  control transfer resolved in D
exc_flush  in  1  exception/eret: flush the whole front end
rs_e, rt_e  in  REG_AW each  E-stage source indices
wr_en_m, wr_reg_m  in  1 / REG_AW  M-stage write
wr_en_w, wr_reg_w  in  1 / REG_AW  W-stage write
stall_f, stall_d  out  1 each  hold PC / IF-ID register
flush_d, flush_e  out  1 each  clear IF-ID / ID-EX register
fwd_a_d, fwd_b_d  out  1 each  D compare operand from M
fwd_a_e, fwd_b_e  out  2 each  E operand select: 10 = M, 01 = W, 00 = RF
mdu_busy  out  1  MDU countdown nonzero
stall_cnt  out  CNT_W  cycles with stall_d=1, saturating

Behaviour:
- Reset (resetn=0 at a clk edge): all sb_cnt[r]=0, mdu_cnt=0, stall_cnt=0. mdu_busy=0. With cleared state, stall_d/stall_f/flush_e=0 unless exc_flush=1.
- issue = ~stall_d & ~exc_flush. This is the D instruction advancing to E this edge.
- Scoreboard, r in 1..NREG-1:
  - On issue & wr_en_d & wr_reg_d==r: sb_cnt[r] := wr_lat_d+1.
  - Otherwise sb_cnt[r] decrements if nonzero.
  - Set overrides decrement; a newer write to the same register overwrites (WAW).
  - wr_reg_d==0 is never recorded.
- Data stall for source s with use_s_d=1 and s!=0:
  - src_stage_d=1: stall if sb_cnt[s]>0.
  - src_stage_d=0: stall if sb_cnt[s]>1.
  - Result: ALU→E-consumer 0 stalls; load→E-consumer 1; ALU→branch 1; load→branch 2. The register file is write-through in W.
- MDU:
  - On issue & mdu_start_d: mdu_cnt := mdu_lat_d; otherwise it decrements if nonzero.
  - mdu_stall = (hilo_read_d | mdu_start_d) & mdu_cnt!=0.
- stall_d = data_stall | mdu_stall; stall_f = stall_d.
- flush_e = stall_d | exc_flush (bubble into E).
- flush_d = exc_flush | (DELAY_SLOT==0 & (branch_taken_d|jump_d) & ~stall_d).
- exc_flush: all sb_cnt and mdu_cnt cleared at that edge. Flush wins over set in the same cycle. In-flight M/W forwarding still applies.
- fwd_a_e:
  - 10 if wr_en_m & wr_reg_m!=0 & wr_reg_m==rs_e;
  - else 01 if the same test on W matches;
  - else 00.
  - M has priority over W. fwd_b_e is the same test on rt_e.
- fwd_a_d = wr_en_m & wr_reg_m!=0 & wr_reg_m==rs_d; fwd_b_d is the same on rt_d.
- stall_cnt increments when stall_d=1 and holds at all-ones.
- Countdowns never underflow. Latency values above the LAT_W maximum are illegal.

Decomposition:
- Shared package hazard_pkg: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10, LAT_ALU=0, LAT_LOAD=1.
- One sub-module, hazard_sb_tbl: the per-register countdown array with set/decrement/clear and two read ports (rs, rt). Stall, forwarding and MDU logic live in the top.

Test Plan:
1. lw r8 (wr_lat_d=1) then add r9,r8,r1 (src_stage_d=0) → stall_d=1 exactly 1 cycle, flush_e=1 that cycle; then fwd_a_e=01 when add is in E.
2. addu r9 then beq r9,r0 (src_stage_d=1) → 1 stall cycle; then fwd_a_d=1. lw r9 then beq r9 → 2 stall cycles.
3. div (mdu_lat_d=32) then mflo → stall_d high 32 cycles; mdu_busy falls with release; stall_cnt=32. The following mult issues without stall.
4. Load to r8 pending (sb_cnt=2) with exc_flush=1 → flush_d=flush_e=1; next cycle a consumer of r8 issues with stall_d=0.
5. wr_reg_d=0 producer, and consumer with use_rt_d=0 and rt_d matching a pending load → stall_d=0 in both cases.
6. DELAY_SLOT=0, branch_taken_d=1, no stall → flush_d=1. Same with DELAY_SLOT=1 → flush_d=0. Reset mid-stall → stall_cnt=0, stall_d=0 next cycle.
